// File: rtl/tern_sel_sequencer.sv
// Round-robin sequencer for five sources driving the select code of the nested-ternary 8:1 mux.
// Optional TERN_SEL_PARITY_EN adds a registered even-parity bit on sel and an unused-code check.
module tern_sel_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic [4:0] grant,
`ifdef TERN_SEL_PARITY_EN
  output logic       sel_par,
`endif
  output logic       xfer
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [4:0]       grant_q, grant_d;
  logic [2:0]       win_q, win_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             dwell_done;
  logic             win_req;
  logic [2:0]       search_from;
  logic [3:0]       pick;
  logic             pick_found;
  logic [2:0]       pick_idx;

  // Returns {found, index}; search begins at (from+1) mod 5 and wraps e -> a.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] from);
    logic [3:0]  res;
    int unsigned k;
    res = '0;
    // Walk farthest-first so the nearest set bit is the last one written.
    for (int i = 5; i >= 1; i--) begin
      k = (32'(from) + 32'(i)) % 32'd5;
      if (r[k]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

  // Fixed source-to-code map dictated by the downstream mux decode.
  function automatic logic [2:0] enc(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b010;
      3'd1:    code = 3'b001;
      3'd2:    code = 3'b000;
      3'd3:    code = 3'b100;
      3'd4:    code = 3'b011;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  assign dwell_done = (cnt_q == '0);
  assign xfer       = valid_q & out_ready & dwell_done;
  assign win_req    = |(req & grant_q);

  // On a transfer the winner becomes the new pointer in the same cycle.
  assign search_from = xfer ? win_q : last_q;
  assign pick        = rr_pick(req, search_from);
  assign pick_found  = pick[3];
  assign pick_idx    = pick[2:0];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    grant_d = grant_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          win_d   = pick_idx;
          sel_d   = enc(pick_idx);
          grant_d = 5'b00001 << pick_idx;
          valid_d = 1'b1;
          cnt_d   = HoldLoad;
        end
      end
      StGrant: begin
        if (xfer) begin
          last_d = win_q;
          if (pick_found) begin
            win_d   = pick_idx;
            sel_d   = enc(pick_idx);
            grant_d = 5'b00001 << pick_idx;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            grant_d = '0;
          end
        end else if (!win_req) begin
          // Abort: winner withdrew before transfer, pointer stays put.
          state_d = StIdle;
          valid_d = 1'b0;
          grant_d = '0;
        end else if (!dwell_done) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 3'b000;
      valid_q <= 1'b0;
      grant_q <= '0;
      win_q   <= 3'd0;
      last_q  <= 3'd4;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign grant     = grant_q;

`ifdef TERN_SEL_PARITY_EN
  logic sel_par_q;

  // Tracks sel_d, so it only changes when sel does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_par_q <= 1'b0;
    else        sel_par_q <= ^sel_d;
  end

  assign sel_par = sel_par_q;

  always @(posedge clk) begin
    if (rst_n && valid_q && (sel_q inside {3'b101, 3'b110, 3'b111})) begin
      $error("tern_sel_sequencer: unused sel code %b driven while valid", sel_q);
    end
  end
`endif

endmodule

// File: tb/tb_tern_sel_sequencer.sv
// Scoreboard bench: two instances (HOLD_CYCLES=1 and 3) share clock and reset.
module tb_tern_sel_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] req1, req3;
  logic       rdy1, rdy3;
  logic [2:0] sel1, sel3;
  logic       valid1, valid3;
  logic [4:0] grant1, grant3;
  logic       xfer1, xfer3;
`ifdef TERN_SEL_PARITY_EN
  logic       par1, par3;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [4:0] grant;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  tern_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req1),
    .out_ready (rdy1),
    .sel       (sel1),
    .sel_valid (valid1),
    .grant     (grant1),
`ifdef TERN_SEL_PARITY_EN
    .sel_par   (par1),
`endif
    .xfer      (xfer1)
  );

  tern_sel_sequencer #(.HOLD_CYCLES(3), .CNT_W(4)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req3),
    .out_ready (rdy3),
    .sel       (sel3),
    .sel_valid (valid3),
    .grant     (grant3),
`ifdef TERN_SEL_PARITY_EN
    .sel_par   (par3),
`endif
    .xfer      (xfer3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req1 = '0; rdy1 = 1'b0; req3 = '0; rdy3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (sel1 !== 3'b000 || valid1 !== 1'b0 || grant1 !== 5'b0) begin
      errors++;
      $display("FAIL reset: sel=%b valid=%b grant=%b, want 000/0/00000", sel1, valid1, grant1);
    end
`ifdef TERN_SEL_PARITY_EN
    checks++;
    if (par1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_par: got %b want 0", par1);
    end
`endif
  endtask

  // HOLD_CYCLES=1, all requesting: a,b,c,d,e,a back to back.
  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    req1 = 5'b11111; rdy1 = 1'b1;
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL rr_latency: sel_valid=%b want 0 in request cycle", valid1);
    end
    sb.push_back('{sel: 3'b010, grant: 5'b00001});
    sb.push_back('{sel: 3'b001, grant: 5'b00010});
    sb.push_back('{sel: 3'b000, grant: 5'b00100});
    sb.push_back('{sel: 3'b100, grant: 5'b01000});
    sb.push_back('{sel: 3'b011, grant: 5'b10000});
    sb.push_back('{sel: 3'b010, grant: 5'b00001});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (valid1 !== 1'b1 || xfer1 !== 1'b1) begin
        errors++;
        $display("FAIL rr_bubble[%0d]: valid=%b xfer=%b want 1/1", i, valid1, xfer1);
      end
      if (xfer1 === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rr_sb_empty[%0d]: unexpected transfer sel=%b", i, sel1);
        end else begin
          e = sb.pop_front();
          if (sel1 !== e.sel || grant1 !== e.grant) begin
            errors++;
            $display("FAIL rr_grant[%0d]: sel=%b grant=%b want %b/%b", i, sel1, grant1,
                     e.sel, e.grant);
          end
`ifdef TERN_SEL_PARITY_EN
          checks++;
          if (par1 !== ^e.sel) begin
            errors++;
            $display("FAIL rr_par[%0d]: got %b want %b", i, par1, ^e.sel);
          end
`endif
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d transfers missing, want 0", sb.size());
      sb.delete();
    end
  endtask

  // HOLD_CYCLES=3, lone requester d: xfer every 3rd cycle, sel never moves.
  task automatic test_dwell();
    do_reset();
    @(negedge clk);
    req3 = 5'b01000; rdy3 = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{sel: 3'b100, grant: 5'b01000});
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (sel3 !== 3'b100 || valid3 !== 1'b1 || xfer3 !== (i % 3 == 2)) begin
        errors++;
        $display("FAIL dwell[%0d]: sel=%b valid=%b xfer=%b want 100/1/%b", i, sel3, valid3,
                 xfer3, (i % 3 == 2));
      end
      if (xfer3 === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dwell_sb_empty[%0d]: extra transfer", i);
        end else begin
          e = sb.pop_front();
          if (sel3 !== e.sel || grant3 !== e.grant) begin
            errors++;
            $display("FAIL dwell_grant[%0d]: sel=%b grant=%b want %b/%b", i, sel3, grant3,
                     e.sel, e.grant);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL dwell_drain: %0d transfers missing, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Consumer stalls 10 cycles; grant to c must hold.
  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req1 = 5'b00100; rdy1 = 1'b0;
    sb.push_back('{sel: 3'b000, grant: 5'b00100});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (sel1 !== 3'b000 || valid1 !== 1'b1 || xfer1 !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: sel=%b valid=%b xfer=%b want 000/1/0", i, sel1, valid1, xfer1);
      end
    end
    @(negedge clk);
    rdy1 = 1'b1;
    #1;
    checks++;
    if (xfer1 !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL stall_release: xfer=%b pending=%0d want 1/1", xfer1, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (sel1 !== e.sel || grant1 !== e.grant) begin
        errors++;
        $display("FAIL stall_grant: sel=%b grant=%b want %b/%b", sel1, grant1, e.sel, e.grant);
      end
    end
    sb.delete();
  endtask

  // Pointer parked on a, b granted then withdrawn: b must win again.
  task automatic test_abort();
    do_reset();
    @(negedge clk);
    req1 = 5'b00001; rdy1 = 1'b1;
    sb.push_back('{sel: 3'b010, grant: 5'b00001});
    @(negedge clk);
    req1 = 5'b00010; rdy1 = 1'b1;
    #1;
    checks++;
    if (xfer1 !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL abort_setup: xfer=%b pending=%0d want 1/1", xfer1, sb.size());
    end else begin
      e = sb.pop_front();
      if (sel1 !== e.sel || grant1 !== e.grant) begin
        errors++;
        $display("FAIL abort_setup_grant: sel=%b grant=%b want %b/%b", sel1, grant1,
                 e.sel, e.grant);
      end
    end
    @(negedge clk);
    rdy1 = 1'b0;
    #1;
    checks++;
    if (sel1 !== 3'b001 || grant1 !== 5'b00010 || valid1 !== 1'b1 || xfer1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_b_grant: sel=%b grant=%b valid=%b xfer=%b want 001/00010/1/0",
               sel1, grant1, valid1, xfer1);
    end
    @(negedge clk);
    req1 = 5'b00000;
    #1;
    checks++;
    if (xfer1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_xfer: xfer=%b want 0", xfer1);
    end
    @(negedge clk);
    req1 = 5'b00011;
    #1;
    checks++;
    if (valid1 !== 1'b0 || grant1 !== 5'b0 || sel1 !== 3'b001) begin
      errors++;
      $display("FAIL abort_idle: valid=%b grant=%b sel=%b want 0/00000/001", valid1, grant1,
               sel1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sel1 !== 3'b001 || grant1 !== 5'b00010 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_regrant: sel=%b grant=%b valid=%b want 001/00010/1", sel1, grant1,
               valid1);
    end
    sb.delete();
  endtask

  // Asynchronous reset in the middle of a grant to e.
  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    req1 = 5'b10000; rdy1 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sel1 !== 3'b011 || valid1 !== 1'b1 || grant1 !== 5'b10000) begin
      errors++;
      $display("FAIL arst_setup: sel=%b valid=%b grant=%b want 011/1/10000", sel1, valid1,
               grant1);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel1 !== 3'b000 || valid1 !== 1'b0 || grant1 !== 5'b0) begin
      errors++;
      $display("FAIL arst_now: sel=%b valid=%b grant=%b want 000/0/00000", sel1, valid1, grant1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req1 = 5'b10001;
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: valid=%b want 0", valid1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sel1 !== 3'b010 || grant1 !== 5'b00001 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL arst_first_a: sel=%b grant=%b valid=%b want 010/00001/1", sel1, grant1,
               valid1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req1 = '0; rdy1 = 1'b0; req3 = '0; rdy3 = 1'b0;
    test_reset();
    test_round_robin();
    test_dwell();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tern_sel_sequencer.md
Name: tern_sel_sequencer

Overview:
- Round-robin sequencer that arbitrates five 8-bit data sources (a..e) and drives the 3-bit select code of the downstream nested-ternary 8:1 result mux.
- Sits directly upstream of that mux.
- Converts per-source requests into an encoded sel with a minimum dwell time and a valid/ready handshake to the consumer of the mux result.

Parameters:
- HOLD_CYCLES, 1, minimum cycles sel is held stable per grant before transfer may occur; legal range 1..2**CNT_W-1.
- CNT_W, 4, width of dwell counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  5  request per source; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e.
- out_ready  input  1  downstream consumer accepts current mux result.
- sel  output  3  registered select code to the mux.
- sel_valid  output  1  sel is a live grant; result is meaningful.
- grant  output  5  registered one-hot grant, same bit order as req; all-zero when idle.
- xfer  output  1  combinational: sel_valid & out_ready & dwell_done.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - sel=3'b000, sel_valid=0, grant=5'b0.
  - Internal last-winner pointer = e (index 4), so a has first priority.
  - Dwell counter = 0.
- Encoding, fixed per source; the mux decode must be honoured exactly:
  - a -> 3'b010
  - b -> 3'b001
  - c -> 3'b000
  - d -> 3'b100
  - e -> 3'b011
  - Codes 101/110/111 are never driven.
- Arbitration:
  - Round-robin search starts at index (last+1) mod 5 and wraps from e to a.
  - The first set req bit wins.
- States:
  - IDLE: sel_valid=0, grant=0, sel holds its last value.
    - If req!=0: register the winner's sel and grant, set sel_valid=1, load counter=HOLD_CYCLES-1, go to GRANT. Latency is one cycle from req to sel_valid.
  - GRANT: sel and grant stay stable. dwell_done = (counter==0); counter decrements each cycle while nonzero.
    - Transfer when xfer=1.
      - Update last = winner.
      - If req (all bits, including the current winner) is nonzero, pick the next winner in the same cycle, reload the counter, and stay in GRANT. Back-to-back grants have no bubble.
      - Otherwise go to IDLE.
    - Abort when the winner's req bit drops before transfer: next cycle sel_valid=0, grant=0, state IDLE, last NOT updated.
      - If abort and xfer coincide, xfer wins.
- out_ready while dwell is not done: ignored, no transfer.
- out_ready while IDLE: ignored.
- HOLD_CYCLES=1: dwell_done is true on the first GRANT cycle.
- Reset asserted mid-GRANT: all outputs and the pointer return to reset values immediately (asynchronously).
- A lone persistent requester is re-granted every transfer. The pointer passes it, wraps, and finds it again.

Optional Feature:
- Macro: TERN_SEL_PARITY_EN.
- When defined:
  - Adds output sel_par (1 bit), registered alongside sel, equal to even parity ^sel.
  - Reset value 0.
  - Updates only when sel updates.
  - Adds internal check: a simulation $error fires if sel is ever an unused code (101/110/111) while sel_valid=1.
- When undefined: port and check are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req=5'b11111, out_ready=1, HOLD_CYCLES=1
  -> sel_valid rises one cycle later.
  -> sel sequence 010,001,000,100,011,010 (a,b,c,d,e,a) on consecutive cycles; grant 00001,00010,00100,01000,10000.
- HOLD_CYCLES=3, req=5'b01000, out_ready=1
  -> sel=3'b100 held 3 cycles per transfer; xfer pulses every 3rd cycle; sel never changes.
- req=5'b00100, out_ready=0 for 10 cycles, then 1
  -> sel=000 and sel_valid=1 held throughout; xfer on the cycle out_ready rises.
- Grant to b (req=5'b00010), drop req[1] before out_ready
  -> next cycle sel_valid=0, grant=0.
  -> Then req=5'b00011: winner is b again, because the pointer did not advance.
- rst_n pulsed low mid-GRANT with sel=3'b011
  -> sel=000, sel_valid=0, grant=0 immediately; after release, first winner among req=5'b10001 is a.
- With TERN_SEL_PARITY_EN and round-robin all five
  -> sel_par follows 1,1,0,1,0; no $error fires.
